// File: rtl/potato_timer.sv
// Countdown-timer control for the potato game: edits MM:SS with a cursor, then
// runs, pauses, resumes and expires a 1 Hz countdown feeding the display memory.
module potato_timer #(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_enter,
   output logic [4:0] select,
   output logic [4:0] second1,
   output logic [4:0] second2,
   output logic [4:0] minute1,
   output logic [4:0] minute2,
   output logic       running,
   output logic       expired
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_DONE} state_t;

   state_t        state;
   logic [CW-1:0] tick_cnt;
   logic [4:0]    pre_s1, pre_s2, pre_m1, pre_m2;
   logic          tick, time_zero, time_one;

   assign tick      = (tick_cnt == LAST_TICK);
   assign time_zero = ({minute2, minute1, second2, second1} == '0);
   // The decrement reaches 00:00 exactly when the current time is 00:01.
   assign time_one  = ({minute2, minute1, second2} == '0) && (second1 == 5'd1);

   function automatic logic [4:0] inc_wrap(input logic [4:0] d, input logic [4:0] top);
      return (d >= top) ? 5'd0 : d + 5'd1;
   endfunction

   function automatic logic [4:0] dec_wrap(input logic [4:0] d, input logic [4:0] top);
      return (d == 5'd0) ? top : d - 5'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_SET;
         select   <= '0;
         second1  <= '0;
         second2  <= '0;
         minute1  <= 5'd1;
         minute2  <= '0;
         pre_s1   <= '0;
         pre_s2   <= '0;
         pre_m1   <= 5'd1;
         pre_m2   <= '0;
         tick_cnt <= '0;
         running  <= 1'b0;
         expired  <= 1'b0;
      end else begin
         case (state)
            ST_SET: begin
               if (btn_enter) begin
                  if (select == 5'd4 && !time_zero) begin
                     pre_s1   <= second1;
                     pre_s2   <= second2;
                     pre_m1   <= minute1;
                     pre_m2   <= minute2;
                     tick_cnt <= '0;
                     state    <= ST_RUN;
                     running  <= 1'b1;
                  end
               end else if (btn_left) begin
                  select <= (select == 5'd0) ? 5'd4 : select - 5'd1;
               end else if (btn_right) begin
                  select <= (select >= 5'd4) ? 5'd0 : select + 5'd1;
               end else if (btn_up) begin
                  case (select)
                     5'd0:    second1 <= inc_wrap(second1, 5'd9);
                     5'd1:    second2 <= inc_wrap(second2, 5'd5);
                     5'd2:    minute1 <= inc_wrap(minute1, 5'd9);
                     5'd3:    minute2 <= inc_wrap(minute2, 5'd9);
                     default: ;
                  endcase
               end else if (btn_down) begin
                  case (select)
                     5'd0:    second1 <= dec_wrap(second1, 5'd9);
                     5'd1:    second2 <= dec_wrap(second2, 5'd5);
                     5'd2:    minute1 <= dec_wrap(minute1, 5'd9);
                     5'd3:    minute2 <= dec_wrap(minute2, 5'd9);
                     default: ;
                  endcase
               end
            end

            ST_RUN: begin
               select   <= 5'd4;
               tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
               if (tick) begin
                  second1 <= dec_wrap(second1, 5'd9);
                  if (second1 == 5'd0) begin
                     second2 <= dec_wrap(second2, 5'd5);
                     if (second2 == 5'd0) begin
                        minute1 <= dec_wrap(minute1, 5'd9);
                        if (minute1 == 5'd0)
                           minute2 <= dec_wrap(minute2, 5'd9);
                     end
                  end
               end
               // Expiry on a tick edge takes precedence over a pause request.
               if (tick && time_one) begin
                  state   <= ST_DONE;
                  running <= 1'b0;
                  expired <= 1'b1;
               end else if (btn_enter) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end
            end

            ST_PAUSE: begin
               if (btn_enter) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else if (btn_left || btn_right) begin
                  state  <= ST_SET;
                  select <= 5'd4;
               end
            end

            ST_DONE: begin
               if (btn_enter) begin
                  second1 <= pre_s1;
                  second2 <= pre_s2;
                  minute1 <= pre_m1;
                  minute2 <= pre_m2;
                  select  <= 5'd4;
                  expired <= 1'b0;
                  state   <= ST_SET;
               end
            end

            default: begin
               state   <= ST_SET;
               running <= 1'b0;
               expired <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_potato_timer.sv
// Scoreboard bench for potato_timer: directed button sequences queue the expected
// outputs; a monitor pops and compares them after the clock edge they target.
module tb_potato_timer;

   localparam logic [5:0] B_NONE = 6'b000000;
   localparam logic [5:0] B_RST  = 6'b100000;
   localparam logic [5:0] B_ENT  = 6'b010000;
   localparam logic [5:0] B_L    = 6'b001000;
   localparam logic [5:0] B_R    = 6'b000100;
   localparam logic [5:0] B_U    = 6'b000010;
   localparam logic [5:0] B_D    = 6'b000001;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
   logic [4:0] select, second1, second2, minute1, minute2;
   logic       running, expired;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct packed {
      int           cyc;
      logic [127:0] nm;
      logic [26:0]  val;
   } exp_t;

   exp_t sb[$];

   potato_timer #(.TICKS_PER_SEC(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_enter (btn_enter),
      .select    (select),
      .second1   (second1),
      .second2   (second2),
      .minute1   (minute1),
      .minute2   (minute2),
      .running   (running),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   // Monitor: after each edge, compare every expectation targeted at that edge.
   initial begin
      exp_t e;
      logic [26:0] act;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = {select, minute2, minute1, second2, second1, running, expired};
            checks++;
            if (act !== e.val || e.cyc != cyc) begin
               failures++;
               $display("FAIL %0s cyc=%0d got sel/m2/m1/s2/s1/run/exp=%h expected=%h",
                        e.nm, cyc, act, e.val);
            end
         end
      end
   end

   task automatic step(input logic [5:0] b);
      @(negedge clk);
      {rst, btn_enter, btn_left, btn_right, btn_up, btn_down} = b;
   endtask

   // Expected outputs after the edge following the most recent step().
   task automatic chk(input logic [127:0] nm, input logic [4:0] sel, m2, m1, s2, s1,
                      input logic run, ex);
      exp_t e;
      e.cyc = cyc + 1;
      e.nm  = nm;
      e.val = {sel, m2, m1, s2, s1, run, ex};
      sb.push_back(e);
   endtask

   initial begin
      step(B_RST); chk("reset1", 0, 0, 1, 0, 0, 0, 0);
      step(B_RST); chk("reset2", 0, 0, 1, 0, 0, 0, 0);
      step(B_NONE); chk("idle", 0, 0, 1, 0, 0, 0, 0);
      step(B_L);    chk("left_wrap", 4, 0, 1, 0, 0, 0, 0);
      step(B_R);    chk("right_wrap", 0, 0, 1, 0, 0, 0, 0);
      step(B_R);    chk("sel1", 1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(B_U); chk("s2_up", 1, 0, 1, 5'((i + 1) % 6), 0, 0, 0);
      end
      step(B_L);    chk("sel0", 0, 0, 1, 0, 0, 0, 0);
      step(B_D);    chk("s1_down", 0, 0, 1, 0, 9, 0, 0);
      step(B_L);    chk("sel4", 4, 0, 1, 0, 9, 0, 0);
      step(B_U);    chk("up_sel4", 4, 0, 1, 0, 9, 0, 0);
      step(B_L);
      step(B_L);    chk("sel2", 2, 0, 1, 0, 9, 0, 0);
      step(B_D);    chk("m1_down", 2, 0, 0, 0, 9, 0, 0);
      step(B_R);
      step(B_R);
      step(B_R);    chk("sel_wrap0", 0, 0, 0, 0, 9, 0, 0);
      step(B_U);    chk("s1_wrap", 0, 0, 0, 0, 0, 0, 0);
      step(B_L | B_U); chk("prio_lu", 4, 0, 0, 0, 0, 0, 0);
      step(B_ENT);  chk("zero_enter", 4, 0, 0, 0, 0, 0, 0);

      // Countdown from 01:00.
      step(B_L);
      step(B_L);
      step(B_U);    chk("m1_up", 2, 0, 1, 0, 0, 0, 0);
      step(B_R);
      step(B_R);
      step(B_ENT);  chk("start", 4, 0, 1, 0, 0, 1, 0);
      step(B_NONE);
      step(B_NONE);
      step(B_NONE); chk("pre_tick", 4, 0, 1, 0, 0, 1, 0);
      step(B_NONE); chk("borrow", 4, 0, 0, 5, 9, 1, 0);
      repeat (235) step(B_NONE);
      chk("at_0001", 4, 0, 0, 0, 1, 1, 0);
      step(B_NONE); chk("expire", 4, 0, 0, 0, 0, 0, 1);
      step(B_U);    chk("done_up", 4, 0, 0, 0, 0, 0, 1);
      step(B_ENT);  chk("ack_0100", 4, 0, 1, 0, 0, 0, 0);

      // Pause with the counter held at 2, then resume.
      step(B_ENT);  chk("run2", 4, 0, 1, 0, 0, 1, 0);
      step(B_NONE);
      step(B_ENT);  chk("pause", 4, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(B_NONE); chk("hold", 4, 0, 1, 0, 0, 0, 0);
      end
      step(B_ENT);  chk("resume", 4, 0, 1, 0, 0, 1, 0);
      step(B_NONE); chk("frac", 4, 0, 1, 0, 0, 1, 0);
      step(B_NONE); chk("frac_tick", 4, 0, 0, 5, 9, 1, 0);
      step(B_ENT);  chk("pause2", 4, 0, 0, 5, 9, 0, 0);
      step(B_R);    chk("pause_set", 4, 0, 0, 5, 9, 0, 0);
      step(B_ENT);  chk("run3", 4, 0, 0, 5, 9, 1, 0);
      step(B_NONE);
      step(B_RST);  chk("rst_run", 0, 0, 1, 0, 0, 0, 0);
      step(B_NONE); chk("post_rst", 0, 0, 1, 0, 0, 0, 0);

      // Program 00:03, expire with enter on the final tick, acknowledge.
      step(B_U);
      step(B_U);
      step(B_U);    chk("s1_3", 0, 0, 1, 0, 3, 0, 0);
      step(B_L);
      step(B_L);
      step(B_L);
      step(B_D);    chk("set_0003", 2, 0, 0, 0, 3, 0, 0);
      step(B_R);
      step(B_R);
      step(B_ENT);  chk("start3", 4, 0, 0, 0, 3, 1, 0);
      repeat (3) step(B_NONE);
      step(B_NONE); chk("t_0002", 4, 0, 0, 0, 2, 1, 0);
      repeat (3) step(B_NONE);
      step(B_NONE); chk("t_0001", 4, 0, 0, 0, 1, 1, 0);
      repeat (3) step(B_NONE);
      step(B_ENT);  chk("done_wins", 4, 0, 0, 0, 0, 0, 1);
      step(B_ENT);  chk("reload", 4, 0, 0, 0, 3, 0, 0);
      step(B_NONE);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
